// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus bundle between one master and the slave side.
//   master modport: drives HADDR/HWRITE/HSIZE/HBURST/HTRANS/HWDATA,
//                   samples HREADY/HRESP/HRDATA
//   slave modport : the mirror image
interface ahb_lite_master_if #(
  parameter int AddresseWidth = 4,
  parameter int DataWidth     = 8
);
  logic [AddresseWidth-1:0] HADDR;
  logic                     HWRITE;
  logic [2:0]               HSIZE;
  logic [2:0]               HBURST;
  logic [1:0]               HTRANS;
  logic [DataWidth-1:0]     HWDATA;
  logic                     HREADY;
  logic                     HRESP;
  logic [DataWidth-1:0]     HRDATA;

  modport master (
    output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Command-driven AHB-Lite master. One accepted command becomes a SINGLE or
// INCR burst of byte beats, each address phase overlapping the previous
// beat's data phase. Read data, a done pulse and an error flag go back to
// the local requester.
// Ports:
//   HCLK, HRESETn          bus clock, async active-low reset
//   CmdValid/CmdReady      command handshake; CmdWrite, CmdAddr, CmdLen (beats-1)
//   WdData/WdValid/WdReady write data stream, popped on each write address phase
//   RdData/RdValid         read data, one-cycle pulse per beat
//   Done/Err               end-of-command pulse, Err=1 when the slave answered ERROR
//   ahb                    AHB-Lite master bus
//
// state | meaning
// IDLE  | ready for a command, bus idle
// ADDR  | first beat's address phase (writes wait here for WdValid)
// BURST | later address phases overlapping previous data phases
// LAST  | all addresses issued, waiting for the final data phase
// ERR   | first ERROR cycle seen, bus idled, waiting for the second cycle
module ahb_lite_master #(
  parameter int AddresseWidth = 4,
  parameter int DataWidth     = 8,
  parameter int LenWidth      = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     CmdValid,
  output logic                     CmdReady,
  input  logic                     CmdWrite,
  input  logic [AddresseWidth-1:0] CmdAddr,
  input  logic [LenWidth-1:0]      CmdLen,
  input  logic [DataWidth-1:0]     WdData,
  input  logic                     WdValid,
  output logic                     WdReady,
  output logic [DataWidth-1:0]     RdData,
  output logic                     RdValid,
  output logic                     Done,
  output logic                     Err,
  ahb_lite_master_if.master        ahb
);

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_BURST, ST_LAST, ST_ERR} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t                   state_q, state_d;
  logic [AddresseWidth-1:0] haddr_q, haddr_d;
  logic                     hwrite_q, hwrite_d;
  logic [2:0]               hburst_q, hburst_d;
  logic [DataWidth-1:0]     hwdata_q, hwdata_d;
  logic [LenWidth-1:0]      len_q, len_d;
  logic [LenWidth:0]        issued_q, issued_d;
  logic [LenWidth:0]        completed_q, completed_d;
  logic [DataWidth-1:0]     rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic [1:0]               htrans;
  logic                     wd_ready;
  logic [LenWidth:0]        beats;
  logic                     dphase;
  logic                     addr_done;

  assign beats  = {1'b0, len_q} + (LenWidth+1)'(1);
  // A data phase is outstanding whenever more beats were issued than completed.
  assign dphase = (issued_q != completed_q);

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hburst_d    = hburst_q;
    hwdata_d    = hwdata_q;
    len_d       = len_q;
    issued_d    = issued_q;
    completed_d = completed_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    htrans      = TR_IDLE;
    wd_ready    = 1'b0;
    addr_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          haddr_d     = CmdAddr;
          hwrite_d    = CmdWrite;
          hburst_d    = (CmdLen == '0) ? 3'b000 : 3'b001;
          len_d       = CmdLen;
          issued_d    = '0;
          completed_d = '0;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR:  htrans = (!hwrite_q || WdValid) ? TR_NONSEQ : TR_IDLE;
      ST_BURST: htrans = (hwrite_q && !WdValid) ? TR_BUSY : TR_SEQ;
      default:  htrans = TR_IDLE;
    endcase

    addr_done = ahb.HREADY && (htrans == TR_NONSEQ || htrans == TR_SEQ);
    if (addr_done) begin
      issued_d = issued_q + (LenWidth+1)'(1);
      haddr_d  = haddr_q + AddresseWidth'(1);
      if (hwrite_q) begin
        wd_ready = 1'b1;
        hwdata_d = WdData;
      end
      state_d = (issued_q + (LenWidth+1)'(1) == beats) ? ST_LAST : ST_BURST;
    end

    if (state_q == ST_ADDR || state_q == ST_BURST || state_q == ST_LAST) begin
      if (dphase && ahb.HREADY && !ahb.HRESP) begin
        completed_d = completed_q + (LenWidth+1)'(1);
        if (!hwrite_q) begin
          rd_valid_d = 1'b1;
          rd_data_d  = ahb.HRDATA;
        end
        if (state_q == ST_LAST) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end else if (dphase && ahb.HRESP && !ahb.HREADY) begin
        // First ERROR cycle: any pending address phase cannot complete
        // (HREADY=0), so dropping to ERR cancels it on the next cycle.
        state_d = ST_ERR;
      end
    end

    if (state_q == ST_ERR && ahb.HREADY) begin
      done_d  = 1'b1;
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hburst_q    <= 3'b000;
      hwdata_q    <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hburst_q    <= hburst_d;
      hwdata_q    <= hwdata_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // HTRANS is decoded from state and WdValid; the requester keeps WdValid
  // asserted until WdReady, so HTRANS holds through wait states.
  assign ahb.HADDR  = haddr_q;
  assign ahb.HWRITE = hwrite_q;
  assign ahb.HSIZE  = 3'b000;
  assign ahb.HBURST = hburst_q;
  assign ahb.HTRANS = htrans;
  assign ahb.HWDATA = hwdata_q;

  assign CmdReady = (state_q == ST_IDLE);
  assign WdReady  = wd_ready;
  assign RdData   = rd_data_q;
  assign RdValid  = rd_valid_q;
  assign Done     = done_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] wd_data;
  logic       wd_valid;
  logic       wd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_lite_master_if #(.AddresseWidth(4), .DataWidth(8)) bus ();

  ahb_lite_master #(.AddresseWidth(4), .DataWidth(8), .LenWidth(4)) dut (
    .HCLK     (clk),
    .HRESETn  (rst_n),
    .CmdValid (cmd_valid),
    .CmdReady (cmd_ready),
    .CmdWrite (cmd_write),
    .CmdAddr  (cmd_addr),
    .CmdLen   (cmd_len),
    .WdData   (wd_data),
    .WdValid  (wd_valid),
    .WdReady  (wd_ready),
    .RdData   (rd_data),
    .RdValid  (rd_valid),
    .Done     (done),
    .Err      (err),
    .ahb      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    #1;
    chk("cmd_ready_accept", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = 4'h0;
    cmd_len    = 4'h0;
    wd_data    = 8'h00;
    wd_valid   = 1'b0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 8'h00;

    // reset state
    tick();
    tick();
    #1;
    chk("rst_htrans", 32'(bus.HTRANS), 0);
    chk("rst_haddr", 32'(bus.HADDR), 0);
    chk("rst_hwdata", 32'(bus.HWDATA), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    rst_n = 1'b1;
    tick();

    // 1: single read at 3
    issue(1'b0, 4'h3, 4'h0);
    #1;
    chk("t1_htrans_nonseq", 32'(bus.HTRANS), 2);
    chk("t1_haddr", 32'(bus.HADDR), 3);
    chk("t1_hburst", 32'(bus.HBURST), 0);
    chk("t1_hwrite", 32'(bus.HWRITE), 0);
    chk("t1_cmd_ready_busy", 32'(cmd_ready), 0);
    tick();
    bus.HRDATA = 8'h5A;
    #1;
    chk("t1_htrans_last", 32'(bus.HTRANS), 0);
    chk("t1_done_early", 32'(done), 0);
    tick();
    #1;
    chk("t1_rd_valid", 32'(rd_valid), 1);
    chk("t1_rd_data", 32'(rd_data), 32'h5A);
    chk("t1_done", 32'(done), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_cmd_ready_after", 32'(cmd_ready), 1);

    // 2: INCR write at E, 4 beats, wrapping address
    issue(1'b1, 4'hE, 4'h3);
    wd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd_data = 8'(8'hA0 + i);
      #1;
      chk("t2_htrans", 32'(bus.HTRANS), (i == 0) ? 2 : 3);
      chk("t2_haddr", 32'(bus.HADDR), (14 + i) % 16);
      chk("t2_wd_ready", 32'(wd_ready), 1);
      chk("t2_hburst", 32'(bus.HBURST), 1);
      if (i > 0) chk("t2_hwdata", 32'(bus.HWDATA), 32'hA0 + i - 1);
      tick();
    end
    wd_valid = 1'b0;
    #1;
    chk("t2_htrans_last", 32'(bus.HTRANS), 0);
    chk("t2_hwdata_last", 32'(bus.HWDATA), 32'hA3);
    chk("t2_wd_ready_last", 32'(wd_ready), 0);
    chk("t2_done_early", 32'(done), 0);
    tick();
    #1;
    chk("t2_done", 32'(done), 1);
    chk("t2_err", 32'(err), 0);

    // 3: write with WdValid gap -> BUSY
    issue(1'b1, 4'h5, 4'h2);
    wd_valid = 1'b1;
    wd_data  = 8'hB0;
    #1;
    chk("t3_c1_htrans", 32'(bus.HTRANS), 2);
    chk("t3_c1_wd_ready", 32'(wd_ready), 1);
    tick();
    wd_valid = 1'b0;
    #1;
    chk("t3_c2_htrans_busy", 32'(bus.HTRANS), 1);
    chk("t3_c2_haddr", 32'(bus.HADDR), 6);
    chk("t3_c2_hwdata", 32'(bus.HWDATA), 32'hB0);
    chk("t3_c2_wd_ready", 32'(wd_ready), 0);
    tick();
    #1;
    chk("t3_c3_htrans_busy", 32'(bus.HTRANS), 1);
    chk("t3_c3_haddr", 32'(bus.HADDR), 6);
    tick();
    wd_valid = 1'b1;
    wd_data  = 8'hB1;
    #1;
    chk("t3_c4_htrans", 32'(bus.HTRANS), 3);
    chk("t3_c4_haddr", 32'(bus.HADDR), 6);
    chk("t3_c4_wd_ready", 32'(wd_ready), 1);
    tick();
    wd_data = 8'hB2;
    #1;
    chk("t3_c5_htrans", 32'(bus.HTRANS), 3);
    chk("t3_c5_haddr", 32'(bus.HADDR), 7);
    chk("t3_c5_hwdata", 32'(bus.HWDATA), 32'hB1);
    tick();
    wd_valid = 1'b0;
    #1;
    chk("t3_c6_htrans", 32'(bus.HTRANS), 0);
    chk("t3_c6_hwdata", 32'(bus.HWDATA), 32'hB2);
    tick();
    #1;
    chk("t3_done", 32'(done), 1);
    chk("t3_err", 32'(err), 0);

    // 4: read burst with 2 wait states on beat 1
    issue(1'b0, 4'h8, 4'h3);
    #1;
    chk("t4_c1_htrans", 32'(bus.HTRANS), 2);
    tick();
    bus.HRDATA = 8'hC0;
    #1;
    chk("t4_c2_htrans", 32'(bus.HTRANS), 3);
    chk("t4_c2_haddr", 32'(bus.HADDR), 9);
    tick();
    bus.HREADY = 1'b0;
    bus.HRDATA = 8'h00;
    #1;
    chk("t4_c3_rd_valid", 32'(rd_valid), 1);
    chk("t4_c3_rd_data", 32'(rd_data), 32'hC0);
    chk("t4_c3_htrans", 32'(bus.HTRANS), 3);
    chk("t4_c3_haddr", 32'(bus.HADDR), 10);
    tick();
    #1;
    chk("t4_c4_rd_valid", 32'(rd_valid), 0);
    chk("t4_c4_htrans", 32'(bus.HTRANS), 3);
    chk("t4_c4_haddr", 32'(bus.HADDR), 10);
    chk("t4_c4_hburst", 32'(bus.HBURST), 1);
    chk("t4_c4_hwrite", 32'(bus.HWRITE), 0);
    tick();
    bus.HREADY = 1'b1;
    bus.HRDATA = 8'hC1;
    #1;
    chk("t4_c5_rd_valid", 32'(rd_valid), 0);
    chk("t4_c5_haddr", 32'(bus.HADDR), 10);
    tick();
    bus.HRDATA = 8'hC2;
    #1;
    chk("t4_c6_rd_valid", 32'(rd_valid), 1);
    chk("t4_c6_rd_data", 32'(rd_data), 32'hC1);
    chk("t4_c6_haddr", 32'(bus.HADDR), 11);
    chk("t4_c6_done", 32'(done), 0);
    tick();
    bus.HRDATA = 8'hC3;
    #1;
    chk("t4_c7_rd_data", 32'(rd_data), 32'hC2);
    chk("t4_c7_htrans", 32'(bus.HTRANS), 0);
    chk("t4_c7_done", 32'(done), 0);
    tick();
    #1;
    chk("t4_c8_rd_valid", 32'(rd_valid), 1);
    chk("t4_c8_rd_data", 32'(rd_data), 32'hC3);
    chk("t4_c8_done", 32'(done), 1);
    chk("t4_c8_err", 32'(err), 0);

    // 5: write burst, ERROR response on beat 1
    issue(1'b1, 4'h0, 4'h3);
    wd_valid = 1'b1;
    wd_data  = 8'hD0;
    #1;
    chk("t5_c1_wd_ready", 32'(wd_ready), 1);
    tick();
    wd_data = 8'hD1;
    #1;
    chk("t5_c2_htrans", 32'(bus.HTRANS), 3);
    chk("t5_c2_wd_ready", 32'(wd_ready), 1);
    tick();
    wd_data    = 8'hD2;
    bus.HRESP  = 1'b1;
    bus.HREADY = 1'b0;
    #1;
    chk("t5_c3_wd_ready", 32'(wd_ready), 0);
    chk("t5_c3_hwdata", 32'(bus.HWDATA), 32'hD1);
    tick();
    bus.HREADY = 1'b1;
    #1;
    chk("t5_c4_htrans_idle", 32'(bus.HTRANS), 0);
    chk("t5_c4_wd_ready", 32'(wd_ready), 0);
    chk("t5_c4_done", 32'(done), 0);
    tick();
    bus.HRESP = 1'b0;
    #1;
    chk("t5_c5_done", 32'(done), 1);
    chk("t5_c5_err", 32'(err), 1);
    chk("t5_c5_htrans", 32'(bus.HTRANS), 0);
    chk("t5_c5_wd_ready", 32'(wd_ready), 0);
    tick();
    #1;
    chk("t5_c6_htrans", 32'(bus.HTRANS), 0);
    chk("t5_c6_done", 32'(done), 0);
    chk("t5_c6_err", 32'(err), 0);
    wd_valid = 1'b0;

    // 6: reset in the middle of a read burst
    issue(1'b0, 4'h4, 4'h3);
    #1;
    chk("t6_c1_htrans", 32'(bus.HTRANS), 2);
    tick();
    bus.HRDATA = 8'hE0;
    #1;
    chk("t6_c2_haddr", 32'(bus.HADDR), 5);
    tick();
    #1;
    chk("t6_c3_haddr", 32'(bus.HADDR), 6);
    chk("t6_c3_rd_valid", 32'(rd_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_htrans", 32'(bus.HTRANS), 0);
    chk("t6_rst_haddr", 32'(bus.HADDR), 0);
    chk("t6_rst_rd_valid", 32'(rd_valid), 0);
    chk("t6_rst_cmd_ready", 32'(cmd_ready), 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("t6_post_done", 32'(done), 0);
      chk("t6_post_rd_valid", 32'(rd_valid), 0);
      chk("t6_post_cmd_ready", 32'(cmd_ready), 1);
      chk("t6_post_htrans", 32'(bus.HTRANS), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
